// File: rtl/mpc_mul_pkg.sv
// mpc_mul_pkg: shared defaults, tag/grant types and the round-robin picker
package mpc_mul_pkg;
  localparam int A_W_DEF = 21;
  localparam int B_W_DEF = 14;
  localparam int P_W_DEF = 35;
  localparam int LAT_DEF = 4;
  localparam int MAX_REQ = 8;
  // id sized for the largest requester count so a single tag type serves every build
  localparam int ID_W = $clog2(MAX_REQ);
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
  typedef struct packed {
    logic            any;
    logic [ID_W-1:0] idx;
  } pick_t;
  // scans farthest-to-nearest from ptr so the nearest asserted index is the one kept
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] v, input logic [ID_W-1:0] ptr, input int n);
    pick_t r;
    int j;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (k < n && v[j]) r = '{any: 1'b1, idx: ID_W'(j)};
    end
    return r;
  endfunction
endpackage

// File: rtl/mpc_mul_tag_pipe.sv
// mpc_mul_tag_pipe: LAT-deep ce-gated {valid,id} shift register with sync clear
module mpc_mul_tag_pipe
  import mpc_mul_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);
  tag_t stg_q [LAT];
  // shift tags in lockstep with the multiplier stages; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
    end else if (ce) begin
      stg_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end
  assign tag_o = stg_q[LAT-1];
  // busy while any stage still carries a live product
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < LAT; i++) busy_o = busy_o | stg_q[i].valid;
  end
endmodule

// File: rtl/mpc_mul_share_arb.sv
// mpc_mul_share_arb: round-robin share of one pipelined multiplier; MPC_MUL_ARB_PERF_EN adds perf counters
module mpc_mul_share_arb
  import mpc_mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF,
  parameter int LAT     = LAT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [A_W-1:0]         mul_a,
  output logic [B_W-1:0]         mul_b,
  output logic                   mul_ce,
  input  logic [P_W-1:0]         mul_p,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [P_W-1:0]         rsp_p,
  output logic                   busy
`ifdef MPC_MUL_ARB_PERF_EN
  ,
  output logic [31:0]            perf_issue_cnt,
  output logic [31:0]            perf_conflict_cnt
`endif
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  pick_t pk;
  logic grant;
  tag_t tag_in, tag_out;
  assign pk        = rr_pick(MAX_REQ'(req_valid), ptr_q, NUM_REQ);
  assign grant     = pk.any & ce & ~reset;
  assign req_ready = grant ? NUM_REQ'(1) << pk.idx : '0;
  assign mul_a     = grant ? req_a[pk.idx*A_W +: A_W] : '0;
  assign mul_b     = grant ? req_b[pk.idx*B_W +: B_W] : '0;
  assign mul_ce    = ce;
  assign ptr_d     = (pk.idx == ID_W'(NUM_REQ - 1)) ? '0 : pk.idx + 1'b1;
  assign tag_in    = {grant, grant ? pk.idx : ID_W'(0)};
  // advance the round-robin pointer past each granted requester
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else if (grant) ptr_q <= ptr_d;
  end
  mpc_mul_tag_pipe #(.LAT(LAT)) u_tags (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .tag_i (tag_in),
    .tag_o (tag_out),
    .busy_o(busy)
  );
  // stalled or resetting cycles hide the response; it re-presents once ce returns
  assign rsp_valid = (tag_out.valid & ce & ~reset) ? NUM_REQ'(1) << tag_out.id : '0;
  assign rsp_p     = mul_p;
`ifdef MPC_MUL_ARB_PERF_EN
  logic [31:0] issue_q, conf_q;
  logic multi;
  assign multi = |(req_valid & (req_valid - 1'b1));
  // saturating grant and contention counters
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q <= '0;
      conf_q  <= '0;
    end else begin
      if (grant && ~&issue_q) issue_q <= issue_q + 1'b1;
      if (ce && multi && ~&conf_q) conf_q <= conf_q + 1'b1;
    end
  end
  assign perf_issue_cnt    = issue_q;
  assign perf_conflict_cnt = conf_q;
`endif
endmodule

// File: tb/tb_mpc_mul_share_arb.sv
// tb_mpc_mul_share_arb: randomized scenarios checked against a queue-based reference model
module tb_mpc_mul_share_arb;
  localparam int N = 4, A_W = 21, B_W = 14, P_W = 35, LAT = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*A_W-1:0] req_a = '0;
  logic [N*B_W-1:0] req_b = '0;
  logic [A_W-1:0] mul_a;
  logic [B_W-1:0] mul_b;
  logic mul_ce;
  logic [P_W-1:0] mul_p;
  logic [N-1:0] rsp_valid;
  logic [P_W-1:0] rsp_p;
  logic busy;
`ifdef MPC_MUL_ARB_PERF_EN
  logic [31:0] perf_issue_cnt, perf_conflict_cnt;
`endif
  int errs = 0, checks = 0;

  mpc_mul_share_arb #(.NUM_REQ(N), .A_W(A_W), .B_W(B_W), .P_W(P_W), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
`ifdef MPC_MUL_ARB_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // external multiplier: 4 ce-qualified stages, reset from the same net
  logic signed [P_W-1:0] mp_q [LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) mp_q[i] <= '0;
    end else if (mul_ce) begin
      mp_q[0] <= $signed(mul_a) * $signed(mul_b);
      for (int i = 1; i < LAT; i++) mp_q[i] <= mp_q[i-1];
    end
  end
  assign mul_p = mp_q[LAT-1];

  // reference model: expected responses are due LAT enabled cycles after their issue
  typedef struct {
    int     due;
    int     id;
    longint p;
  } exp_t;
  exp_t exp_q[$];
  int mptr = 0, ticks = 0, rsp_seen = 0;
  bit m_any;
  int m_g;
  logic [N-1:0] m_ready, m_rv;
  logic signed [A_W-1:0] m_a;
  logic signed [B_W-1:0] m_b;
  longint m_p;
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0) begin
        errs++;
        $display("FAIL reset_gate ready=%b rsp=%b want 0000/0000", req_ready, rsp_valid);
      end
      mptr = 0;
      exp_q.delete();
    end else begin
      m_any = 0;
      m_g = 0;
      if (ce) for (int k = 0; k < N; k++) if (!m_any && req_valid[(mptr+k)%N]) begin m_any = 1; m_g = (mptr + k) % N; end
      m_ready = m_any ? N'(1) << m_g : '0;
      m_a = m_any ? req_a[m_g*A_W +: A_W] : '0;
      m_b = m_any ? req_b[m_g*B_W +: B_W] : '0;
      checks++;
      if (req_ready !== m_ready) begin errs++; $display("FAIL grant t=%0t got=%b want=%b", $time, req_ready, m_ready); end
      checks++;
      if (mul_a !== m_a || mul_b !== m_b) begin errs++; $display("FAIL issue_operands t=%0t got=%h,%h want=%h,%h", $time, mul_a, mul_b, m_a, m_b); end
      checks++;
      if (mul_ce !== ce) begin errs++; $display("FAIL mul_ce t=%0t got=%b want=%b", $time, mul_ce, ce); end
      m_rv = '0;
      m_p = 0;
      if (ce && exp_q.size() > 0 && exp_q[0].due == ticks) begin m_rv = N'(1) << exp_q[0].id; m_p = exp_q[0].p; end
      checks++;
      if (rsp_valid !== m_rv || (m_rv != '0 && longint'($signed(rsp_p)) !== m_p)) begin
        errs++;
        $display("FAIL response t=%0t got=%b/%0d want=%b/%0d", $time, rsp_valid, $signed(rsp_p), m_rv, m_p);
      end
      if (m_rv != '0) begin void'(exp_q.pop_front()); rsp_seen++; end
      if (ce) begin
        if (m_any) begin
          exp_q.push_back('{ticks + LAT, m_g, longint'(m_a) * longint'(m_b)});
          mptr = (m_g + 1) % N;
        end
        ticks++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i);
    req_a[i*A_W +: A_W] = A_W'($urandom);
    req_b[i*B_W +: B_W] = B_W'($urandom);
  endtask

  task automatic do_reset;
    tick;
    reset = 1'b1;
    req_valid = '0;
    ce = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    req_valid = '0;
    while (busy !== 1'b0 && n < 40) begin tick; n++; end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL drain_timeout busy=%b want 0", busy); end
  endtask

  task automatic test_reset;
    tick;
    reset = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i);
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errs++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin errs++; $display("FAIL reset_state busy=%b rsp=%b want 0", busy, rsp_valid); end
    tick;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
      errs++;
      $display("FAIL post_reset busy=%b rsp=%b ready=%b want 0", busy, rsp_valid, req_ready);
    end
  endtask

  task automatic test_single;
    tick;
    req_valid = 4'b0001;
    req_a[0 +: A_W] = 21'h100000;
    req_b[0 +: B_W] = 14'd8191;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    for (int c = 1; c <= LAT; c++) begin
      tick;
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (c < LAT) begin
        if (rsp_valid !== '0) begin errs++; $display("FAIL single_early c=%0d got=%b want=0000", c, rsp_valid); end
      end else if (rsp_valid !== 4'b0001 || longint'($signed(rsp_p)) !== -64'sd8588886016) begin
        errs++;
        $display("FAIL single_rsp got=%b/%0d want=0001/-8588886016", rsp_valid, $signed(rsp_p));
      end
    end
  endtask

  task automatic test_round_robin;
    int base, lg;
    logic [N-1:0] rv;
    do_reset;
    for (int i = 0; i < N; i++) set_op(i);
    base = rsp_seen;
    lg = -1;
    rv = '1;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (k >= 9) rv[lg] = 1'b0;
      else if (lg >= 0) set_op(lg);
      req_valid = rv;
      @(negedge clk);
      checks++;
      if (req_ready !== N'(1) << (k % N)) begin errs++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, N'(1) << (k % N)); end
      lg = k % N;
    end
    tick;
    drain;
    checks++;
    if (rsp_seen - base != 12) begin errs++; $display("FAIL rr_count got=%0d want=12", rsp_seen - base); end
  endtask

  task automatic test_ce_stall;
    int found;
    logic [N-1:0] rv;
    tick;
    set_op(1);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errs++; $display("FAIL stall_issue got=%b want=0010", req_ready); end
    rv = 4'b1101;
    set_op(0);
    set_op(2);
    set_op(3);
    for (int c = 1; c <= 2; c++) begin
      tick;
      ce = 1'b0;
      req_valid = rv;
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || rsp_valid !== '0 || mul_ce !== 1'b0) begin
        errs++;
        $display("FAIL stall_cycle c=%0d ready=%b rsp=%b mul_ce=%b want 0", c, req_ready, rsp_valid, mul_ce);
      end
    end
    found = -1;
    for (int c = 3; c < 20 && found < 0; c++) begin
      tick;
      ce = 1'b1;
      req_valid = rv;
      @(negedge clk);
      rv = rv & ~req_ready;
      if (rsp_valid[1] === 1'b1) found = c;
    end
    checks++;
    if (found != 6) begin errs++; $display("FAIL stall_latency got=%0d want=6", found); end
    checks++;
    if (rsp_valid !== 4'b0010) begin errs++; $display("FAIL stall_rsp got=%b want=0010", rsp_valid); end
    tick;
    drain;
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    logic want_busy;
    for (int c = 0; c <= 12; c++) begin
      tick;
      if (c < 8) begin set_op(3); req_valid = 4'b1000; end
      else req_valid = '0;
      @(negedge clk);
      if (c < 8) begin
        checks++;
        if (req_ready !== 4'b1000) begin errs++; $display("FAIL b2b_ready c=%0d got=%b want=1000", c, req_ready); end
      end
      want_busy = (c >= 1 && c <= 11);
      checks++;
      if (busy !== want_busy) begin errs++; $display("FAIL b2b_busy c=%0d got=%b want=%b", c, busy, want_busy); end
      if (c >= 4 && c <= 11) begin
        checks++;
        if (rsp_valid !== 4'b1000) begin errs++; $display("FAIL b2b_rsp c=%0d got=%b want=1000", c, rsp_valid); end
        else pulses++;
      end
    end
    checks++;
    if (pulses != 8) begin errs++; $display("FAIL b2b_pulses got=%0d want=8", pulses); end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] rv;
    rv = 4'b0111;
    for (int i = 0; i < 3; i++) set_op(i);
    for (int c = 0; c < 3; c++) begin
      tick;
      req_valid = rv;
      @(negedge clk);
      checks++;
      if ($countones(req_ready) != 1 || (req_ready & ~rv) != '0) begin errs++; $display("FAIL mid_issue c=%0d got=%b valid=%b", c, req_ready, rv); end
      rv = rv & ~req_ready;
    end
    tick;
    req_valid = '0;
    tick;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== '0) begin errs++; $display("FAIL mid_reset_rsp got=%b want=0000", rsp_valid); end
    for (int c = 5; c <= 12; c++) begin
      tick;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin errs++; $display("FAIL mid_discard c=%0d rsp=%b busy=%b want 0", c, rsp_valid, busy); end
    end
    tick;
    set_op(0);
    set_op(3);
    req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_ptr got=%b want=0001", req_ready); end
    tick;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin errs++; $display("FAIL mid_next got=%b want=1000", req_ready); end
    tick;
    drain;
  endtask

`ifdef MPC_MUL_ARB_PERF_EN
  task automatic test_perf;
    int lg = -1;
    logic [N-1:0] want;
    do_reset;
    set_op(0);
    set_op(2);
    for (int k = 0; k < 10; k++) begin
      tick;
      if (lg >= 0) set_op(lg);
      req_valid = 4'b0101;
      @(negedge clk);
      want = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      checks++;
      if (req_ready !== want) begin errs++; $display("FAIL perf_grant k=%0d got=%b want=%b", k, req_ready, want); end
      lg = (k % 2 == 0) ? 0 : 2;
    end
    tick;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (perf_issue_cnt !== 32'd10 || perf_conflict_cnt !== 32'd10) begin
      errs++;
      $display("FAIL perf_counts got=%0d/%0d want=10/10", perf_issue_cnt, perf_conflict_cnt);
    end
    tick;
    drain;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_ce_stall;
    test_back_to_back;
    test_reset_mid;
`ifdef MPC_MUL_ARB_PERF_EN
    test_perf;
`endif
    tick;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
